// File: rtl/uart_rx_frame.sv
// UART receiver with optional parity that assembles FRAME_BYTES characters into one frame.
// A partial frame is dropped on a framing error, a parity error or an inter-character timeout.
module uart_rx_frame #(
    parameter int BAUD_DIV     = 28,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FRAME_BYTES  = 6,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                             sclk,
    input  logic                             s_rst_n,
    input  logic                             rs232_rx,
    output logic [DATA_BITS-1:0]             byte_data,
    output logic                             byte_vld,
    output logic [FRAME_BYTES*DATA_BITS-1:0] frame_data,
    output logic                             frame_vld,
    output logic [2:0]                       err
);

    localparam int FRAME_W  = FRAME_BYTES * DATA_BITS;
    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam int FCNT_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int TO_W     = $clog2(TO_LIMIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_BYTES - 1);
    // The idle counter starts at 0 on the cycle after the stop sample, so firing at
    // LIMIT-2 places the registered err[2] exactly LIMIT cycles after that sample.
    localparam logic [TO_W-1:0]   TO_FIRE   = TO_W'(TO_LIMIT - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                rx_meta_r;
    logic                rx_sync_r;
    logic                rx_prev_r;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                par_err_r;
    logic [FCNT_W-1:0]   frm_cnt_r;
    logic [FRAME_W-1:0]  frame_buf_r;
    logic [TO_W-1:0]     idle_cnt_r;

    logic                fall_s;
    logic                half_s;
    logic                full_s;
    logic                data_smp_s;
    logic                par_smp_s;
    logic                stop_err_s;
    logic                par_fail_s;
    logic                byte_ok_s;
    logic                frame_done_s;
    logic                timeout_s;
    logic [FRAME_W-1:0]  buf_next_s;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~^d;
        end else begin
            return ^d;
        end
    endfunction

    assign fall_s     = rx_prev_r & ~rx_sync_r;
    assign half_s     = (baud_cnt_r == BAUD_HALF);
    assign full_s     = (baud_cnt_r == BAUD_LAST);
    assign buf_next_s = (frame_buf_r << DATA_BITS) | FRAME_W'(shift_r);

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rs232_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // FSM state register.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_s = START;
                else        state_s = IDLE;
            end
            START: begin
                if (half_s) state_s = rx_sync_r ? IDLE : DATA;
                else        state_s = START;
            end
            DATA: begin
                if (full_s && (bit_cnt_r == BIT_LAST)) state_s = (PARITY != 0) ? PAR : STOP;
                else                                   state_s = DATA;
            end
            PAR: begin
                if (full_s) state_s = STOP;
                else        state_s = PAR;
            end
            STOP: begin
                if (full_s) state_s = IDLE;
                else        state_s = STOP;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: sample strobes and result pulses (registered further down).
    always_comb begin
        data_smp_s   = 1'b0;
        par_smp_s    = 1'b0;
        stop_err_s   = 1'b0;
        par_fail_s   = 1'b0;
        byte_ok_s    = 1'b0;
        frame_done_s = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                timeout_s = ~fall_s && (frm_cnt_r != '0) && (idle_cnt_r == TO_FIRE);
            end
            DATA: begin
                data_smp_s = full_s;
            end
            PAR: begin
                par_smp_s = full_s;
            end
            STOP: begin
                if (full_s) begin
                    if (!rx_sync_r) begin
                        stop_err_s = 1'b1;
                    end else if (par_err_r) begin
                        par_fail_s = 1'b1;
                    end else begin
                        byte_ok_s    = 1'b1;
                        frame_done_s = (frm_cnt_r == FCNT_LAST);
                    end
                end else begin
                    byte_ok_s = 1'b0;
                end
            end
            default: begin
                data_smp_s = 1'b0;
            end
        endcase
    end

    // Bit timing, data shift register and parity check.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_err_r  <= 1'b0;
        end else begin
            if (state_r == IDLE || (state_r == START && half_s) || full_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + 1'b1;
            end
            if (state_r == IDLE) begin
                bit_cnt_r <= '0;
            end else if (data_smp_s) begin
                bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? '0 : bit_cnt_r + 1'b1;
            end
            if (data_smp_s) begin
                shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
            end
            if (state_r == IDLE) begin
                par_err_r <= 1'b0;
            end else if (par_smp_s) begin
                par_err_r <= (rx_sync_r != parity_bit(shift_r));
            end
        end
    end

    // Frame assembly, inter-character timeout and registered outputs.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            frm_cnt_r   <= '0;
            frame_buf_r <= '0;
            idle_cnt_r  <= '0;
            byte_data   <= '0;
            byte_vld    <= 1'b0;
            frame_data  <= '0;
            frame_vld   <= 1'b0;
            err         <= 3'b000;
        end else begin
            byte_vld  <= byte_ok_s;
            frame_vld <= frame_done_s;
            err       <= {timeout_s, par_fail_s, stop_err_s};
            if (byte_ok_s) begin
                byte_data   <= shift_r;
                frame_buf_r <= buf_next_s;
                if (frame_done_s) begin
                    frame_data <= buf_next_s;
                    frm_cnt_r  <= '0;
                end else begin
                    frm_cnt_r <= frm_cnt_r + 1'b1;
                end
            end else if (stop_err_s || par_fail_s || timeout_s) begin
                frm_cnt_r <= '0;
            end
            if (state_r != IDLE || fall_s || frm_cnt_r == '0 || timeout_s) begin
                idle_cnt_r <= '0;
            end else begin
                idle_cnt_r <= idle_cnt_r + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: a no-parity instance and an even-parity instance share clock and reset.
module tb_uart_rx_frame;
    localparam int BIT = 28;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        rx_p = 1'b1;
    logic [7:0]  byte_data, pbyte_data;
    logic        byte_vld, pbyte_vld, frame_vld, pframe_vld;
    logic [47:0] frame_data, pframe_data;
    logic [2:0]  err, perr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_byte_cyc = 0;
    int to_cyc = 0;

    logic [7:0]  byte_q[$], pbyte_q[$];
    logic [47:0] frame_q[$], pframe_q[$];
    logic [2:0]  err_q[$], perr_q[$];
    int          cnt = 0, pcnt = 0;
    logic [47:0] buf_m = '0, pbuf_m = '0, last_frame = '0;

    uart_rx_frame dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .rs232_rx(rx),
        .byte_data(byte_data), .byte_vld(byte_vld),
        .frame_data(frame_data), .frame_vld(frame_vld), .err(err)
    );

    uart_rx_frame #(.PARITY(2)) dut_p (
        .sclk(sclk), .s_rst_n(s_rst_n), .rs232_rx(rx_p),
        .byte_data(pbyte_data), .byte_vld(pbyte_vld),
        .frame_data(pframe_data), .frame_vld(pframe_vld), .err(perr)
    );

    always #10 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor for the no-parity instance.
    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (byte_vld) begin
                last_byte_cyc = cyc;
                chk("byte_expected", 64'(byte_q.size() != 0), 64'd1);
                if (byte_q.size() != 0) chk("byte_data", 64'(byte_data), 64'(byte_q.pop_front()));
            end
            if (frame_vld) begin
                chk("frame_expected", 64'(frame_q.size() != 0), 64'd1);
                if (frame_q.size() != 0) chk("frame_data", 64'(frame_data), 64'(frame_q.pop_front()));
            end
            if (err != 3'b000) begin
                if (err[2]) to_cyc = cyc;
                chk("err_expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) chk("err", 64'(err), 64'(err_q.pop_front()));
            end
        end
    end

    // Monitor for the even-parity instance.
    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (pbyte_vld) begin
                chk("pbyte_expected", 64'(pbyte_q.size() != 0), 64'd1);
                if (pbyte_q.size() != 0) chk("pbyte_data", 64'(pbyte_data), 64'(pbyte_q.pop_front()));
            end
            if (pframe_vld) begin
                chk("pframe_expected", 64'(pframe_q.size() != 0), 64'd1);
                if (pframe_q.size() != 0) chk("pframe_data", 64'(pframe_data), 64'(pframe_q.pop_front()));
            end
            if (perr != 3'b000) begin
                chk("perr_expected", 64'(perr_q.size() != 0), 64'd1);
                if (perr_q.size() != 0) chk("perr", 64'(perr), 64'(perr_q.pop_front()));
            end
        end
    end

    task automatic drive_bit(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else      rx = v;
        repeat (BIT) @(negedge sclk);
    endtask

    task automatic send_char(input bit to_p, input logic [7:0] d, input logic stop_b,
                             input bit has_par, input logic par_b);
        drive_bit(to_p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
        if (has_par) drive_bit(to_p, par_b);
        drive_bit(to_p, stop_b);
        if (!stop_b) drive_bit(to_p, 1'b1);
    endtask

    task automatic tx_good(input bit to_p, input logic [7:0] d);
        if (to_p) begin
            pbyte_q.push_back(d);
            pbuf_m = {pbuf_m[39:0], d};
            if (pcnt == 5) begin
                pframe_q.push_back(pbuf_m);
                pcnt = 0;
            end else begin
                pcnt++;
            end
            send_char(1'b1, d, 1'b1, 1'b1, ^d);
        end else begin
            byte_q.push_back(d);
            buf_m = {buf_m[39:0], d};
            if (cnt == 5) begin
                frame_q.push_back(buf_m);
                last_frame = buf_m;
                cnt = 0;
            end else begin
                cnt++;
            end
            send_char(1'b0, d, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic tx_frame(input bit to_p, input logic [47:0] f);
        logic [47:0] v;
        v = f;
        for (int i = 5; i >= 0; i--) tx_good(to_p, v[i*8 +: 8]);
    endtask

    initial begin
        logic [47:0] f1;
        logic [47:0] f2;
        f1 = 48'hDEADBEEF1234;
        f2 = 48'h0F1E2D3C4B5A;
        repeat (3) @(negedge sclk);
        chk("rst_byte_vld", 64'(byte_vld), 64'd0);
        chk("rst_byte_data", 64'(byte_data), 64'd0);
        chk("rst_frame_data", 64'(frame_data), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        s_rst_n = 1'b1;
        repeat (10) @(negedge sclk);

        // Back-to-back reference frame.
        tx_frame(1'b0, 48'h55AA01020304);
        repeat (40) @(negedge sclk);
        chk("frame1_value", 64'(frame_data), 64'h55AA01020304);

        // Two frames separated by a long idle gap; first frame must hold meanwhile.
        tx_frame(1'b0, f1);
        repeat (1705) @(negedge sclk);
        for (int i = 5; i >= 1; i--) tx_good(1'b0, f1[i*8 +: 8] ^ f2[i*8 +: 8]);
        chk("frame_hold", 64'(frame_data), 64'(f1));
        tx_good(1'b0, f1[7:0] ^ f2[7:0]);
        repeat (40) @(negedge sclk);

        // Inter-character timeout after three bytes.
        tx_good(1'b0, 8'h11);
        tx_good(1'b0, 8'h22);
        tx_good(1'b0, 8'h33);
        err_q.push_back(3'b100);
        cnt = 0;
        repeat (700) @(negedge sclk);
        chk("timeout_latency", 64'(to_cyc - last_byte_cyc), 64'd559);
        tx_frame(1'b0, 48'hA1B2C3D4E5F6);
        repeat (40) @(negedge sclk);

        // Short glitch on the line produces nothing.
        rx = 1'b0;
        repeat (10) @(negedge sclk);
        rx = 1'b1;
        repeat (100) @(negedge sclk);

        // Framing error on byte 2 drops the partial frame; remaining 4 bytes then time out.
        tx_good(1'b0, 8'h5C);
        err_q.push_back(3'b001);
        cnt = 0;
        send_char(1'b0, 8'h6D, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tx_good(1'b0, 8'(8'h70 + i));
        err_q.push_back(3'b100);
        cnt = 0;
        repeat (700) @(negedge sclk);
        chk("frame_keep_after_err", 64'(frame_data), 64'(last_frame));

        // Even parity: 0x07 with a wrong then a correct parity bit.
        perr_q.push_back(3'b010);
        pcnt = 0;
        send_char(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        tx_good(1'b1, 8'h07);
        for (int i = 0; i < 5; i++) tx_good(1'b1, 8'(8'h90 + 3 * i));
        repeat (40) @(negedge sclk);

        // Reset in the middle of the fourth byte of a frame.
        tx_good(1'b1, 8'hC1);
        tx_good(1'b1, 8'hC2);
        tx_good(1'b1, 8'hC3);
        rx_p = 1'b0;
        repeat (2 * BIT + 5) @(negedge sclk);
        s_rst_n = 1'b0;
        rx_p = 1'b1;
        repeat (3) @(negedge sclk);
        chk("midrst_pframe", 64'(pframe_data), 64'd0);
        chk("midrst_pbyte", 64'(pbyte_data), 64'd0);
        chk("midrst_perr_vld", 64'({perr, pbyte_vld, pframe_vld}), 64'd0);
        chk("midrst_frame", 64'(frame_data), 64'd0);
        pcnt = 0;
        cnt = 0;
        s_rst_n = 1'b1;
        repeat (20) @(negedge sclk);
        tx_frame(1'b1, 48'h3344556677FE);
        repeat (40) @(negedge sclk);
        chk("pframe_after_rst", 64'(pframe_data), 64'h3344556677FE);

        chk("left_bytes", 64'(byte_q.size() + pbyte_q.size()), 64'd0);
        chk("left_frames", 64'(frame_q.size() + pframe_q.size()), 64'd0);
        chk("left_errs", 64'(err_q.size() + perr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 28, meaning sclk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per character; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter FRAME_BYTES, default 6, meaning characters per assembled frame; legal range 1..16.
REQ-005 SHALL have parameter TIMEOUT_BITS, default 20, meaning idle bit-times allowed between characters of one frame.
REQ-006 SHALL have port sclk, input, 1, the single clock.
REQ-007 SHALL have port s_rst_n, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port rs232_rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port byte_data, output, DATA_BITS, last received character.
REQ-010 SHALL have port byte_vld, output, 1, one-cycle pulse when a valid character is received.
REQ-011 SHALL have port frame_data, output, FRAME_BYTES*DATA_BITS, assembled frame; first character in the most significant position.
REQ-012 SHALL have port frame_vld, output, 1, one-cycle pulse when frame_data is updated.
REQ-013 SHALL have port err, output, 3, one-cycle pulses {timeout, parity_err, stop_err}.

Function
REQ-014 SHALL pass rs232_rx through a 2-flop synchroniser; all decoding uses the synchronised value.
REQ-015 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-016 IDLE->START on a synchronised high-to-low transition; the bit counter starts from 0.
REQ-017 In START, SHALL sample at cycle BAUD_DIV/2 (integer division); low -> DATA, high -> IDLE (glitch, no error, no pulse).
REQ-018 In DATA, SHALL sample each bit BAUD_DIV cycles after the previous sample, LSB first, for DATA_BITS samples; then go to PAR if PARITY!=0, else STOP.
REQ-019 In PAR, SHALL sample one bit; mismatch against the computed odd/even parity sets a pending parity error.
REQ-020 In STOP, SHALL sample one bit, then return to IDLE on the cycle after the sample.
- Stop low: pulse err[0].
- Else, pending parity error: pulse err[1].
- Else: update byte_data and pulse byte_vld.
REQ-021 byte_vld and err SHALL assert on the cycle after the stop sample.
REQ-022 SHALL shift each valid character into a frame buffer and count characters 0..FRAME_BYTES-1.
REQ-023 On the FRAME_BYTES-th valid character:
- copy the buffer to frame_data and pulse frame_vld in the same cycle as that byte_vld;
- clear the character count.
REQ-024 frame_data SHALL hold its value until the next complete frame.
REQ-025 Any err[0] or err[1] SHALL discard the partial frame (count to 0); frame_data is unchanged.
REQ-026 With count>0 in IDLE, SHALL count idle cycles.
- Reaching TIMEOUT_BITS*BAUD_DIV: discard the partial frame and pulse err[2].
- The counter clears on any start detection.
REQ-027 With count==0, the timeout counter SHALL be held at 0 and err[2] never asserts.
REQ-028 A falling edge during DATA/PAR/STOP SHALL be ignored; after STOP, a line already low SHALL be detected as a new start only after a high is seen.
REQ-029 Counter widths SHALL derive from parameters via $clog2; no count wraps silently.

Reset
REQ-030 When s_rst_n is low at a sclk rising edge:
- state IDLE, synchroniser flops at 1, all counters 0;
- byte_data 0, frame_data 0, byte_vld 0, frame_vld 0, err 0.
REQ-031 Reset SHALL take effect mid-character or mid-frame, discarding partial data; reception resumes only on a new falling edge after reset release.

Verification (defaults, sclk 20 ns, bit 560 ns)
REQ-032 Send 0x55,0xAA,0x01,0x02,0x03,0x04 back-to-back -> six byte_vld pulses; one frame_vld with frame_data=48'h55AA01020304.
REQ-033 Send two frames 34.1 us apart -> two frame_vld pulses, no err; frame_data holds the first frame until the second frame completes.
REQ-034 Send 3 bytes, then idle 20*560 ns -> err[2] pulses exactly 560 cycles after the third stop sample; the next 6 bytes form a clean frame.
REQ-035 Pull rs232_rx low for 200 ns -> no byte_vld, no err, state returns to IDLE.
REQ-036 Send byte 2 with stop bit 0 -> err[0] pulses; bytes 3..6 alone produce no frame_vld.
REQ-037 PARITY=2: send 0x07 with parity bit 0 -> err[1] pulses; the same byte with parity bit 1 -> byte_vld, byte_data=8'h07. Also assert reset mid-byte 4 -> all outputs 0, and a following full frame assembles correctly.
